// File: rtl/spi_reg_bank.sv
// SPI mode-0 slave register bank, oversampled on clk: write, readback on cipo,
// per-write strobe, out-of-range filtering and a saturating aborted-frame counter.
module spi_reg_bank #(
  parameter int unsigned       ADDR_W   = 7,
  parameter int unsigned       DATA_W   = 8,
  parameter int unsigned       NUM_REGS = 5,
  parameter logic [DATA_W-1:0] RST_VAL  = '0
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         sclk,
  input  logic                         ncs,
  input  logic                         copi,
  output logic                         cipo,
  output logic                         cipo_oe,
  output logic [NUM_REGS*DATA_W-1:0]   regs_out,
  output logic                         wr_stb,
  output logic [ADDR_W-1:0]            wr_addr,
  output logic [7:0]                   abort_cnt
);

  localparam int unsigned FRAME_W = 1 + ADDR_W + DATA_W;
  localparam int unsigned HDR_W   = 1 + ADDR_W;
  localparam int unsigned SH_W    = ADDR_W + DATA_W;
  localparam int unsigned CNT_W   = $clog2(FRAME_W + 1);

  typedef enum logic [2:0] {IDLE, SHIFT, READ, COMMIT, DONE} state_t;

  state_t              state;
  logic [2:0]          sclk_sync;
  logic [1:0]          ncs_sync;
  logic [1:0]          copi_sync;
  logic [SH_W-1:0]     shreg;
  logic [SH_W-1:0]     shreg_nxt;
  logic [CNT_W-1:0]    cnt;
  logic [CNT_W-1:0]    cnt_nxt;
  logic [DATA_W-1:0]   out_sh;
  logic [DATA_W-1:0]   rd_data;
  logic [ADDR_W-1:0]   hdr_addr;
  logic [ADDR_W-1:0]   frm_addr;
  logic [DATA_W-1:0]   frm_data;
  logic                hdr_rw;
  logic                frm_hit;
  logic                cipo_q;
  logic                ncs_seen;
  logic                sclk_rise;
  logic                sclk_fall;
  logic                ncs_s;
  logic                copi_s;
  logic [DATA_W-1:0]   regs [NUM_REGS];

  // Input synchronisers; sclk gets a third stage for edge detection
  always_ff @(posedge clk) begin
    if (rst_n) begin
      sclk_sync <= '0;
      ncs_sync  <= '0;
      copi_sync <= '0;
    end else begin
      sclk_sync <= {sclk_sync[1:0], sclk};
      ncs_sync  <= {ncs_sync[0], ncs};
      copi_sync <= {copi_sync[0], copi};
    end
  end

  assign sclk_rise = sclk_sync[1] & ~sclk_sync[2];
  assign sclk_fall = ~sclk_sync[1] & sclk_sync[2];
  assign ncs_s     = ncs_sync[1];
  assign copi_s    = copi_sync[1];
  assign cipo_oe   = ~ncs_s;
  assign cipo      = cipo_q & cipo_oe;

  // Header decode on the incoming bit, frame decode on the completed shifter
  always_comb begin
    shreg_nxt = {shreg[SH_W-2:0], copi_s};
    cnt_nxt   = cnt + CNT_W'(1);
    hdr_addr  = shreg_nxt[ADDR_W-1:0];
    hdr_rw    = shreg_nxt[ADDR_W];
    frm_addr  = shreg[DATA_W +: ADDR_W];
    frm_data  = shreg[DATA_W-1:0];
    rd_data   = '0;
    frm_hit   = 1'b0;
    for (int unsigned i = 0; i < NUM_REGS; i++) begin
      if (hdr_addr == ADDR_W'(i)) rd_data = regs[i];
      if (frm_addr == ADDR_W'(i)) frm_hit = 1'b1;
    end
  end

  always_comb begin
    regs_out = '0;
    for (int unsigned i = 0; i < NUM_REGS; i++) regs_out[i*DATA_W +: DATA_W] = regs[i];
  end

  // Frame FSM. ncs_seen blocks a frame from starting until ncs has been seen
  // deasserted after reset, since the zeroed ncs synchroniser reads as selected.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      state     <= IDLE;
      shreg     <= '0;
      cnt       <= '0;
      out_sh    <= '0;
      cipo_q    <= 1'b0;
      wr_stb    <= 1'b0;
      wr_addr   <= '0;
      abort_cnt <= '0;
      ncs_seen  <= 1'b0;
      for (int unsigned i = 0; i < NUM_REGS; i++) regs[i] <= RST_VAL;
    end else begin
      wr_stb <= 1'b0;
      if (ncs_s) ncs_seen <= 1'b1;
      case (state)
        IDLE: begin
          shreg  <= '0;
          cnt    <= '0;
          out_sh <= '0;
          cipo_q <= 1'b0;
          if (!ncs_s && ncs_seen) state <= SHIFT;
        end
        SHIFT: begin
          if (ncs_s) begin
            state     <= IDLE;
            abort_cnt <= (abort_cnt == 8'hFF) ? abort_cnt : abort_cnt + 8'd1;
          end else if (sclk_rise) begin
            shreg <= shreg_nxt;
            cnt   <= cnt_nxt;
            if (cnt_nxt == CNT_W'(HDR_W) && !hdr_rw) begin
              state  <= READ;
              out_sh <= rd_data;
            end else if (cnt_nxt == CNT_W'(FRAME_W)) begin
              state <= COMMIT;
            end
          end
        end
        READ: begin
          if (ncs_s) begin
            state     <= IDLE;
            abort_cnt <= (abort_cnt == 8'hFF) ? abort_cnt : abort_cnt + 8'd1;
          end else begin
            if (sclk_rise) begin
              cnt <= cnt_nxt;
              if (cnt_nxt == CNT_W'(FRAME_W)) state <= DONE;
            end
            if (sclk_fall) begin
              cipo_q <= out_sh[DATA_W-1];
              out_sh <= out_sh << 1;
            end
          end
        end
        COMMIT: begin
          if (frm_hit) begin
            for (int unsigned i = 0; i < NUM_REGS; i++)
              if (frm_addr == ADDR_W'(i)) regs[i] <= frm_data;
            wr_stb  <= 1'b1;
            wr_addr <= frm_addr;
          end
          state <= DONE;
        end
        DONE: begin
          if (ncs_s) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_reg_bank.sv
// Scoreboard bench for spi_reg_bank: default instance plus a 4/16/16 instance.
module tb_spi_reg_bank;

  localparam int HALF = 5;

  typedef struct {
    logic [6:0]   addr;
    logic [255:0] regs;
  } wr_exp_t;

  logic         clk = 1'b0;
  logic         rst;
  logic         sclk;
  logic         ncs;
  logic         ncs2;
  logic         copi;
  logic         cipo, cipo_oe, wr_stb;
  logic [39:0]  regs_out;
  logic [6:0]   wr_addr;
  logic [7:0]   abort_cnt;
  logic         cipo2, cipo_oe2, wr_stb2;
  logic [255:0] regs_out2;
  logic [3:0]   wr_addr2;
  logic [7:0]   abort_cnt2;

  int n_checks = 0;
  int n_pass   = 0;
  int strobes1 = 0;
  int strobes2 = 0;

  wr_exp_t     wr_q[$];
  wr_exp_t     wr_q2[$];
  logic [15:0] rd_q[$];

  always #5 clk = ~clk;

  spi_reg_bank dut (
    .clk(clk), .rst_n(rst), .sclk(sclk), .ncs(ncs), .copi(copi),
    .cipo(cipo), .cipo_oe(cipo_oe), .regs_out(regs_out),
    .wr_stb(wr_stb), .wr_addr(wr_addr), .abort_cnt(abort_cnt)
  );

  spi_reg_bank #(.ADDR_W(4), .DATA_W(16), .NUM_REGS(16), .RST_VAL(16'h0000)) dut2 (
    .clk(clk), .rst_n(rst), .sclk(sclk), .ncs(ncs2), .copi(copi),
    .cipo(cipo2), .cipo_oe(cipo_oe2), .regs_out(regs_out2),
    .wr_stb(wr_stb2), .wr_addr(wr_addr2), .abort_cnt(abort_cnt2)
  );

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Drive nbits sclk pulses of a width-bit frame, MSB first; bits past width are 1s
  task automatic send(input bit sel, input logic [31:0] word, input int width,
                      input int nbits, input bit chk_oe);
    if (sel) ncs2 = 1'b0; else ncs = 1'b0;
    repeat (4) @(negedge clk);
    if (chk_oe) check("cipo_oe during frame", 256'(sel ? cipo_oe2 : cipo_oe), 1);
    for (int i = 0; i < nbits; i++) begin
      copi = (i < width) ? word[width-1-i] : 1'b1;
      repeat (HALF) @(negedge clk);
      sclk = 1'b1;
      repeat (HALF) @(negedge clk);
      sclk = 1'b0;
    end
    repeat (HALF) @(negedge clk);
    ncs  = 1'b1;
    ncs2 = 1'b1;
    repeat (8) @(negedge clk);
  endtask

  task automatic push_wr(input logic [6:0] a, input logic [255:0] r);
    wr_exp_t e;
    e.addr = a;
    e.regs = r;
    wr_q.push_back(e);
  endtask

  // Write-strobe monitor: every strobe must match a queued expectation
  always @(negedge clk) begin
    wr_exp_t e;
    if (wr_stb === 1'b1) begin
      strobes1++;
      if (wr_q.size() == 0) check("wr_stb expected", 256'(wr_q.size() != 0), 1);
      else begin
        e = wr_q.pop_front();
        check("wr_addr", 256'(wr_addr), 256'(e.addr));
        check("regs_out after write", 256'(regs_out), e.regs);
      end
    end
    if (wr_stb2 === 1'b1) begin
      strobes2++;
      if (wr_q2.size() == 0) check("wr_stb2 expected", 256'(wr_q2.size() != 0), 1);
      else begin
        e = wr_q2.pop_front();
        check("wr_addr2", 256'(wr_addr2), 256'(e.addr));
        check("regs_out2 after write", regs_out2, e.regs);
      end
    end
  end

  // Read monitor: samples cipo at each sclk rise; complete read frames are scored
  initial begin
    bit          sel;
    bit          rw;
    int          nb;
    logic [31:0] cap;
    logic [15:0] exp;
    logic [15:0] got;
    forever begin
      wait (ncs === 1'b0 || ncs2 === 1'b0);
      sel = (ncs2 === 1'b0);
      nb  = 0;
      cap = '0;
      rw  = 1'b0;
      while ((sel ? ncs2 : ncs) === 1'b0) begin
        @(posedge sclk or posedge ncs or posedge ncs2);
        if (sclk === 1'b1) begin
          if (nb == 0) rw = copi;
          cap = {cap[30:0], sel ? cipo2 : cipo};
          nb++;
        end
      end
      if (!rw && nb == (sel ? 21 : 16)) begin
        got = sel ? cap[15:0] : {8'h00, cap[7:0]};
        if (rd_q.size() == 0) check("read expected", 256'(rd_q.size() != 0), 1);
        else begin
          exp = rd_q.pop_front();
          check(sel ? "cipo read data (16b)" : "cipo read data", 256'(got), 256'(exp));
        end
      end
    end
  end

  initial begin
    repeat (300000) @(posedge clk);
    $display("FAIL watchdog: bench still running after 300000 cycles");
    $fatal(1);
  end

  initial begin
    wr_exp_t e2;
    rst  = 1'b1;
    sclk = 1'b0;
    ncs  = 1'b1;
    ncs2 = 1'b1;
    copi = 1'b0;
    repeat (5) @(negedge clk);
    rst = 1'b0;
    repeat (6) @(negedge clk);
    check("reset regs_out", 256'(regs_out), 0);
    check("reset abort_cnt", 256'(abort_cnt), 0);
    check("reset wr_addr", 256'(wr_addr), 0);
    check("reset cipo", 256'(cipo), 0);
    check("reset cipo_oe", 256'(cipo_oe), 0);

    push_wr(7'd2, 256'h00_00_AA_00_00);
    send(0, 32'h82AA, 16, 16, 1);
    push_wr(7'd4, 256'h5C_00_AA_00_00);
    send(0, 32'h845C, 16, 16, 0);
    rd_q.push_back(16'h005C);
    send(0, 32'h0400, 16, 16, 0);

    send(0, 32'h90FF, 16, 16, 0);
    check("regs after out-of-range write", 256'(regs_out), 256'h5C_00_AA_00_00);
    rd_q.push_back(16'h0000);
    send(0, 32'h1000, 16, 16, 0);

    send(0, 32'h81AB, 16, 10, 0);
    check("abort_cnt after one abort", 256'(abort_cnt), 1);
    check("regs after abort", 256'(regs_out), 256'h5C_00_AA_00_00);
    for (int i = 0; i < 254; i++) send(0, 32'h8100, 16, 2, 0);
    check("abort_cnt at 255", 256'(abort_cnt), 255);
    for (int i = 0; i < 5; i++) send(0, 32'h8100, 16, 2, 0);
    check("abort_cnt saturated", 256'(abort_cnt), 255);

    push_wr(7'd0, 256'h5C_00_AA_00_33);
    send(0, 32'h8033, 16, 20, 0);
    check("abort_cnt after overlong frame", 256'(abort_cnt), 255);

    // Reset in the middle of a frame, ncs released while reset is held
    ncs = 1'b0;
    repeat (4) @(negedge clk);
    for (int i = 0; i < 6; i++) begin
      copi = 1'b1;
      repeat (HALF) @(negedge clk);
      sclk = 1'b1;
      repeat (HALF) @(negedge clk);
      sclk = 1'b0;
    end
    rst = 1'b1;
    repeat (3) @(negedge clk);
    ncs = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (6) @(negedge clk);
    check("mid-frame reset regs_out", 256'(regs_out), 0);
    check("mid-frame reset abort_cnt", 256'(abort_cnt), 0);
    check("mid-frame reset wr_addr", 256'(wr_addr), 0);
    check("mid-frame reset cipo", 256'(cipo), 0);
    check("mid-frame reset cipo_oe", 256'(cipo_oe), 0);

    push_wr(7'd3, 256'h00_77_00_00_00);
    send(0, 32'h8377, 16, 16, 1);
    rd_q.push_back(16'h0077);
    send(0, 32'h0300, 16, 16, 0);
    check("abort_cnt after clean frames", 256'(abort_cnt), 0);

    e2.addr = 7'd15;
    e2.regs = 256'hBEEF << 240;
    wr_q2.push_back(e2);
    send(1, 32'h1FBEEF, 21, 21, 1);
    rd_q.push_back(16'hBEEF);
    send(1, 32'h0F0000, 21, 21, 0);
    check("regs_out unchanged by other instance", 256'(regs_out), 256'h00_77_00_00_00);

    repeat (20) @(negedge clk);
    check("write queue drained", 256'(wr_q.size()), 0);
    check("write queue 2 drained", 256'(wr_q2.size()), 0);
    check("read queue drained", 256'(rd_q.size()), 0);
    check("wr_stb pulse count", 256'(strobes1), 4);
    check("wr_stb2 pulse count", 256'(strobes2), 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/spi_reg_bank.md
Name: spi_reg_bank

Overview:
- Parametrised successor to the current write-only SPI peripheral.
- SPI mode-0 slave, oversampled on the system clock. Exposes a bank of NUM_REGS registers of DATA_W bits to the PWM/output logic.
- Adds register readback on CIPO, a per-write strobe, out-of-range handling, and a saturating aborted-frame counter.

Parameters:
- ADDR_W, 7, address field width in bits.
- DATA_W, 8, data field and register width in bits.
- NUM_REGS, 5, number of implemented registers (addresses 0..NUM_REGS-1); must be no greater than 2^ADDR_W.
- RST_VAL, 0, reset value of every register (DATA_W bits).

Ports:
- clk  in  1  system clock; the only clock; sclk is treated as data.
- rst_n  in  1  reset: synchronous, active-high (1 = reset, sampled on posedge clk).
- sclk  in  1  SPI serial clock, asynchronous to clk.
- ncs  in  1  active-low chip select, asynchronous.
- copi  in  1  controller-out/peripheral-in data, asynchronous.
- cipo  out  1  peripheral-out data, registered.
- cipo_oe  out  1  output enable for cipo pad; high while synchronised ncs is low.
- regs_out  out  NUM_REGS*DATA_W  flat register bank; register i at bits [i*DATA_W +: DATA_W].
- wr_stb  out  1  one-cycle pulse on each committed write.
- wr_addr  out  ADDR_W  address of the last committed write; valid with wr_stb and held afterwards.
- abort_cnt  out  8  count of aborted frames; saturates at 255.

Behaviour:
- Synchronisers:
  - copi and ncs pass through 2 flops; sclk passes through 3 flops.
  - Rise = stage2 & ~stage3; fall = ~stage2 & stage3.
  - sclk must be no faster than clk/8.
- Frame format, MSB first, FRAME_W = 1+ADDR_W+DATA_W bits: bit0 = R/W (1 = write, 0 = read), then address, then data.
- FSM states:
  - IDLE: synchronised ncs high; bit count 0; shift register 0; cipo 0. Go to SHIFT when ncs is sampled low.
  - SHIFT: on each rise, shift copi in and increment the bit count. After 1+ADDR_W bits with R/W = 0, go to READ. After FRAME_W bits with R/W = 1, go to COMMIT.
  - READ: load register[addr] into the output shifter, or 0 if addr ≥ NUM_REGS. Its MSB drives cipo on the next fall; each later fall shifts out the next bit. Rises still count. After FRAME_W bits, go to DONE.
  - COMMIT: one cycle. If addr < NUM_REGS, write the data field into register[addr], pulse wr_stb and update wr_addr. If addr ≥ NUM_REGS, do not write and do not pulse wr_stb. Then go to DONE.
  - DONE: ignore further sclk edges; extra bits are discarded. Go to IDLE on ncs high.
- Latency:
  - regs_out and wr_stb change on the clk edge after the one that captures the final data bit.
  - Total latency from the final physical sclk rise to regs_out is at most 5 clk cycles.
- Abort: if ncs rises while in SHIFT or READ with count < FRAME_W:
  - return to IDLE;
  - no register write;
  - abort_cnt increments by 1 unless it is already 255.
  - ncs rising from DONE, or from IDLE, is not an abort.
- Back-to-back frames: ncs high for ≥ 1 synchronised cycle separates frames. Bit count and shifter clear in IDLE.
- Simultaneous events: if ncs rises in the same cycle as the final rise, the rise is ignored and the frame counts as an abort. The ncs check has priority.
- Reset: rst_n high at any time, including mid-frame, returns to IDLE and sets:
  - all registers to RST_VAL;
  - abort_cnt, wr_stb, wr_addr, cipo and all synchroniser flops to 0.
- cipo_oe = ~(synchronised ncs), combinational from a flop; cipo is forced to 0 when cipo_oe is low.

Test Plan:
- Write, default params: frame 1_0000010_10101010 → register 2 = 0xAA, one wr_stb pulse, wr_addr = 2; other registers stay 0.
- Read-back: write 0x5C to addr 4, then read frame 0_0000100_xxxxxxxx → cipo bits 0,1,0,1,1,1,0,0 on the final 8 falls; no wr_stb.
- Out of range: write 0xFF to addr 0x10 → regs_out unchanged, no wr_stb; reading addr 0x10 returns 0x00.
- Abort: raise ncs after 10 bits of a write to addr 1 → register 1 unchanged, abort_cnt = 1. After 260 aborts abort_cnt = 255.
- Overlong frame plus reset: 20 sclk pulses writing 0x33 to addr 0 → register 0 = 0x33, with a single wr_stb. Then assert rst_n mid-frame → all outputs return to reset values, and the next clean frame works.
- Parameter sweep: ADDR_W = 4, DATA_W = 16, NUM_REGS = 16 → write 0xBEEF to addr 15 and read it back correctly.
